// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MIPS pipeline datapath.
//   - Write-back source select encodings (MemToReg) used by the MEM->WB stage
//     and by the control unit that drives it.
//   - Register-file constants ($zero index).
//   - Default datapath widths, used as parameter defaults by pipeline stages.
// ----------------------------------------------------------------------------
package mips_pkg;

    // Default datapath widths.
    localparam int DATA_W_DFLT     = 32;
    localparam int REG_ADDR_W_DFLT = 5;

    // Write-back source select. Encodings above WB_SEL_PC4 are not produced
    // by the decoder; the stage treats them like WB_SEL_ALU.
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

    // Architectural $zero register index; writes to it are discarded.
    localparam int REG_ZERO = 0;

endpackage : mips_pkg

// File: rtl/pipe_reg_en_clr.sv
// ----------------------------------------------------------------------------
// pipe_reg_en_clr
//   Generic pipeline register group, updated on the FALLING clock edge.
//   Asynchronous active-low reset to zero, synchronous clear (priority) and
//   load enable.
//
// Parameters
//   WIDTH  register width in bits.
//
// Ports
//   clk    in   1      clock; state changes on negedge.
//   rst_n  in   1      asynchronous active-low reset, forces q to 0.
//   en     in   1      load d into q this edge.
//   clr    in   1      load 0 into q this edge; wins over en.
//   d      in   WIDTH  next value.
//   q      out  WIDTH  registered value.
// ----------------------------------------------------------------------------
module pipe_reg_en_clr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_reg_en_clr

// File: rtl/pipe_mem_wb_stage.sv
// ----------------------------------------------------------------------------
// pipe_mem_wb_stage
//   MEM->WB pipeline register with stall (hold), flush (bubble insert), valid
//   tracking, $zero write suppression, a registered write-back data mux and a
//   retired-instruction counter. All state changes on the FALLING clock edge;
//   every output comes straight from a register.
//
// Parameters
//   DATA_W      width of ReadDataRAM, ALUResult, PC_4 and WriteData.
//   REG_ADDR_W  register-file address width.
//   SEL_W       MemToReg select width (>= 2).
//   CNT_W       retired-instruction counter width (wraps, no saturation).
//
// Ports
//   clk            in   1           pipeline clock (negedge active).
//   reset          in   1           asynchronous active-low reset.
//   Stall          in   1           hold every W register this edge.
//   Flush          in   1           load a bubble this edge (beats Stall).
//   Valid_M        in   1           M stage holds a real instruction.
//   MemToReg_M     in   SEL_W       write-back source select.
//   RegWrite_M     in   1           M-stage register-write enable.
//   ReadDataRAM_M  in   DATA_W      data-RAM read data.
//   ALUResult_M    in   DATA_W      ALU result.
//   PC_4_M         in   DATA_W      PC+4 (jal link value).
//   WriteReg_M     in   REG_ADDR_W  destination register.
//   Valid_W        out  1           W stage holds a real instruction.
//   RegWrite_W     out  1           qualified register-file write enable.
//   WriteReg_W     out  REG_ADDR_W  destination register.
//   WriteData_W    out  DATA_W      selected write-back data.
//   MemToReg_W     out  SEL_W       registered select.
//   RetiredCount   out  CNT_W       instructions retired since reset.
// ----------------------------------------------------------------------------
module pipe_mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  Valid_M,
    input  logic [SEL_W-1:0]      MemToReg_M,
    input  logic                  RegWrite_M,
    input  logic [DATA_W-1:0]     ReadDataRAM_M,
    input  logic [DATA_W-1:0]     ALUResult_M,
    input  logic [DATA_W-1:0]     PC_4_M,
    input  logic [REG_ADDR_W-1:0] WriteReg_M,
    output logic                  Valid_W,
    output logic                  RegWrite_W,
    output logic [REG_ADDR_W-1:0] WriteReg_W,
    output logic [DATA_W-1:0]     WriteData_W,
    output logic [SEL_W-1:0]      MemToReg_W,
    output logic [CNT_W-1:0]      RetiredCount
);

    // Control group layout: {Valid, RegWrite, WriteReg, MemToReg}.
    localparam int CTRL_W = 2 + REG_ADDR_W + SEL_W;

    // Write-back source mux. Unused encodings fall back to the ALU result so
    // a stray select never writes garbage from an unrelated source.
    function automatic logic [DATA_W-1:0] wb_select(
        input logic [SEL_W-1:0]  sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] pc4
    );
        logic [DATA_W-1:0] res;
        res = alu;
        if (sel == SEL_W'(WB_SEL_MEM)) begin
            res = mem;
        end else if (sel == SEL_W'(WB_SEL_PC4)) begin
            res = pc4;
        end
        return res;
    endfunction

    logic                  reg_write_q_p0;
    logic [CTRL_W-1:0]     ctrl_d_p0;
    logic [CTRL_W-1:0]     ctrl_q_p1;
    logic [DATA_W-1:0]     wb_data_p0;
    logic                  load_en;
    logic                  retire;
    logic [CNT_W-1:0]      cnt_next;

    // ---- M stage: qualify write enable and select write-back data ----------
    // A $zero destination or an invalid instruction must never reach the
    // register file or the forwarding unit as a write.
    assign reg_write_q_p0 = RegWrite_M & Valid_M
                          & (WriteReg_M != REG_ADDR_W'(REG_ZERO));

    assign ctrl_d_p0  = {Valid_M, reg_write_q_p0, WriteReg_M, MemToReg_M};
    assign wb_data_p0 = wb_select(MemToReg_M, ALUResult_M, ReadDataRAM_M, PC_4_M);

    // Flush is wired to the clear input, which beats enable, so Flush > Stall.
    assign load_en = ~Stall;

    // ---- W stage registers -------------------------------------------------
    pipe_reg_en_clr #(
        .WIDTH (CTRL_W)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (load_en),
        .clr   (Flush),
        .d     (ctrl_d_p0),
        .q     (ctrl_q_p1)
    );

    pipe_reg_en_clr #(
        .WIDTH (DATA_W)
    ) u_data_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (load_en),
        .clr   (Flush),
        .d     (wb_data_p0),
        .q     (WriteData_W)
    );

    assign {Valid_W, RegWrite_W, WriteReg_W, MemToReg_W} = ctrl_q_p1;

    // ---- Retirement counter ------------------------------------------------
    // The W entry retires whenever it leaves the stage: a normal advance, or
    // being replaced by a flush. A stalled entry has not left yet.
    assign retire   = Valid_W & (~Stall | Flush);
    assign cnt_next = RetiredCount + CNT_W'(1);

    pipe_reg_en_clr #(
        .WIDTH (CNT_W)
    ) u_cnt_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (retire),
        .clr   (1'b0),
        .d     (cnt_next),
        .q     (RetiredCount)
    );

endmodule : pipe_mem_wb_stage
